// File: rtl/spi_sfr_core.sv
// 8-bit SPI master/slave peripheral behind a small SFR register file.
// One byte per transfer, CPOL/CPHA selectable, interrupt on byte completion.
module spi_sfr_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sfraddr_w,
  input  logic [2:0] sfraddr_r,
  input  logic       sfrwe,
  input  logic [7:0] spssn_i,
  input  logic [7:0] spidata_i,
  input  logic       mosii,
  input  logic       misoi,
  input  logic       scki,
  input  logic       ssn,
  output logic [7:0] spssn_o,
  output logic [7:0] sfrdatao,
  output logic       intspi,
  output logic       mosio,
  output logic       misoo,
  output logic       scko,
  output logic       SPC0
);

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_START = 2'd1,
    M_XFER  = 2'd2
  } m_state_e;

  logic [7:0] spcr_q, spbr_q, rxbuf_q, spssn_q;
  logic       spie_q, spif_q, wcol_q;

  m_state_e   m_state_q;
  logic [7:0] m_div_q, m_tx_q, m_rx_q;
  logic [3:0] m_edge_q;
  logic       m_bit_q, scko_q;

  logic       s_scki_q, s_scki_prev_q, s_ssn_q, s_mosi_q, s_bit_q;
  logic [2:0] s_cnt_q;
  logic [7:0] s_tx_q, s_rx_q;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  logic spe, dord, mstr, cpol, cpha, master_en, slave_en;
  assign spe       = spcr_q[6];
  assign dord      = spcr_q[5];
  assign mstr      = spcr_q[4];
  assign cpol      = spcr_q[3];
  assign cpha      = spcr_q[2];
  assign master_en = spe & mstr;
  assign slave_en  = spe & ~mstr;

  // Any SPCR write that changes its value abandons a transfer in flight.
  logic wr_spcr, spcr_chg, wr_spdr, wr_spsr;
  assign wr_spcr  = sfrwe && (sfraddr_w == 3'd0);
  assign spcr_chg = wr_spcr && (spidata_i != spcr_q);
  assign wr_spdr  = sfrwe && (sfraddr_w == 3'd3);
  assign wr_spsr  = sfrwe && (sfraddr_w == 3'd4);

  // Both shifters always emit bit 7 first; LSB-first order is handled by reversal.
  logic [7:0] tx_byte;
  assign tx_byte = dord ? rev8(spidata_i) : spidata_i;

  logic       m_tick, m_lead, m_trail, m_sample, m_shift, m_done, m_done_v;
  logic       m_start, m_wcol;
  logic [7:0] m_rx_next, m_rx_fin;
  assign m_tick    = (m_state_q == M_XFER) && (m_div_q == spbr_q);
  assign m_lead    = m_tick && !m_edge_q[0];
  assign m_trail   = m_tick &&  m_edge_q[0];
  assign m_sample  = cpha ? m_trail : m_lead;
  assign m_shift   = cpha ? m_lead  : m_trail;
  assign m_done    = m_tick && (m_edge_q == 4'd15);
  assign m_done_v  = m_done && master_en && !spcr_chg;
  assign m_start   = master_en && wr_spdr && (m_state_q == M_IDLE);
  assign m_wcol    = master_en && wr_spdr && (m_state_q != M_IDLE);
  assign m_rx_next = {m_rx_q[6:0], misoi};
  assign m_rx_fin  = cpha ? m_rx_next : m_rx_q;

  logic       s_edge, s_lead, s_trail, s_sample, s_shift, s_done, s_load, s_wcol;
  logic [7:0] s_rx_next;
  assign s_edge    = slave_en && !s_ssn_q && (s_scki_q != s_scki_prev_q);
  assign s_lead    = s_edge && (s_scki_q != cpol);
  assign s_trail   = s_edge && (s_scki_q == cpol);
  assign s_sample  = cpha ? s_trail : s_lead;
  assign s_shift   = cpha ? s_lead  : s_trail;
  assign s_done    = s_sample && (s_cnt_q == 3'd7) && !spcr_chg;
  assign s_load    = slave_en && wr_spdr && s_ssn_q;
  assign s_wcol    = slave_en && wr_spdr && !s_ssn_q;
  assign s_rx_next = {s_rx_q[6:0], s_mosi_q};

  // Master: one start cycle, then 16 half-periods of (spbr_q+1) clocks each.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state_q <= M_IDLE;
      m_div_q   <= 8'd0;
      m_edge_q  <= 4'd0;
      m_tx_q    <= 8'd0;
      m_rx_q    <= 8'd0;
      m_bit_q   <= 1'b0;
      scko_q    <= 1'b0;
    end else if (!master_en || spcr_chg) begin
      m_state_q <= M_IDLE;
      m_div_q   <= 8'd0;
      m_edge_q  <= 4'd0;
      scko_q    <= cpol;
    end else begin
      case (m_state_q)
        M_IDLE: begin
          scko_q <= cpol;
          if (m_start) begin
            m_state_q <= M_START;
            m_tx_q    <= tx_byte;
            m_rx_q    <= 8'd0;
            m_bit_q   <= 1'b0;
            m_div_q   <= 8'd0;
            m_edge_q  <= 4'd0;
          end
        end
        M_START: m_state_q <= M_XFER;
        M_XFER: begin
          if (m_tick) begin
            scko_q   <= ~scko_q;
            m_div_q  <= 8'd0;
            m_edge_q <= m_edge_q + 4'd1;
            if (m_shift) begin
              m_bit_q <= m_tx_q[7];
              m_tx_q  <= {m_tx_q[6:0], 1'b0};
            end
            if (m_sample) m_rx_q <= m_rx_next;
            if (m_done) m_state_q <= M_IDLE;
          end else begin
            m_div_q <= m_div_q + 8'd1;
          end
        end
        default: m_state_q <= M_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_scki_q      <= 1'b0;
      s_scki_prev_q <= 1'b0;
      s_ssn_q       <= 1'b0;
      s_mosi_q      <= 1'b0;
      s_bit_q       <= 1'b0;
      s_cnt_q       <= 3'd0;
      s_tx_q        <= 8'd0;
      s_rx_q        <= 8'd0;
    end else begin
      s_scki_q      <= scki;
      s_scki_prev_q <= s_scki_q;
      s_ssn_q       <= ssn;
      s_mosi_q      <= mosii;
      if (!slave_en || spcr_chg) begin
        s_cnt_q <= 3'd0;
        s_bit_q <= 1'b0;
      end else if (s_ssn_q) begin
        s_cnt_q <= 3'd0;
        s_bit_q <= 1'b0;
        if (s_load) s_tx_q <= tx_byte;
      end else begin
        if (s_shift) begin
          s_bit_q <= s_tx_q[7];
          s_tx_q  <= {s_tx_q[6:0], 1'b0};
        end
        if (s_sample) begin
          s_rx_q  <= s_rx_next;
          s_cnt_q <= s_cnt_q + 3'd1;
        end
      end
    end
  end

  // Completion beats a same-cycle software clear of SPIF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spcr_q  <= 8'd0;
      spie_q  <= 1'b0;
      spbr_q  <= 8'd0;
      rxbuf_q <= 8'd0;
      spif_q  <= 1'b0;
      wcol_q  <= 1'b0;
      spssn_q <= 8'hFF;
    end else begin
      if (wr_spcr) spcr_q <= spidata_i;
      if (sfrwe && (sfraddr_w == 3'd1)) spie_q <= spidata_i[0];
      if (sfrwe && (sfraddr_w == 3'd2)) spbr_q <= spidata_i;
      if (m_done_v || s_done) spif_q <= 1'b1;
      else if (wr_spdr || (wr_spsr && spidata_i[7])) spif_q <= 1'b0;
      if (m_wcol || s_wcol) wcol_q <= 1'b1;
      else if (m_start || s_load) wcol_q <= 1'b0;
      if (m_done_v) rxbuf_q <= dord ? rev8(m_rx_fin) : m_rx_fin;
      else if (s_done) rxbuf_q <= dord ? rev8(s_rx_next) : s_rx_next;
      spssn_q <= master_en ? spssn_i : 8'hFF;
    end
  end

  always_comb begin
    sfrdatao = 8'd0;
    case (sfraddr_r)
      3'd0: sfrdatao = spcr_q;
      3'd1: sfrdatao = {7'd0, spie_q};
      3'd2: sfrdatao = spbr_q;
      3'd3: sfrdatao = rxbuf_q;
      3'd4: sfrdatao = {spif_q, wcol_q, 5'd0, (m_state_q != M_IDLE)};
      default: sfrdatao = 8'd0;
    endcase
  end

  assign spssn_o = spssn_q;
  assign intspi  = spif_q & spie_q;
  assign SPC0    = spcr_q[0];
  assign scko    = master_en ? scko_q : (slave_en ? cpol : 1'b0);
  assign mosio   = master_en ? (cpha ? m_bit_q : m_tx_q[7]) : 1'b0;
  assign misoo   = (slave_en && !s_ssn_q) ? (cpha ? s_bit_q : s_tx_q[7]) : 1'b0;

endmodule

// File: tb/tb_spi_sfr_core.sv
// Bench for spi_sfr_core: a master instance looped to a slave instance,
// with a behavioural MISO source and direct slave pin drive for corner cases.
module tb_spi_sfr_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [2:0] m_aw, m_ar, s_aw, s_ar;
  logic       m_we, s_we;
  logic [7:0] m_din, s_din, m_spssn_i;
  logic       m_misoi, s_scki, s_ssn, s_mosii;
  logic [7:0] m_spssn_o, m_sfrdo, s_spssn_o, s_sfrdo;
  logic       m_int, m_mosio, m_misoo, m_scko, m_spc0;
  logic       s_int, s_mosio, s_misoo, s_scko, s_spc0;

  logic       loop_en, use_model, tb_scki, tb_ssn, tb_mosi;
  logic [7:0] model_sh;

  logic [7:0] exp_q[$];
  logic [7:0] sexp_q[$];
  int vectors = 0;
  int miscompares = 0;

  assign m_misoi = use_model ? model_sh[7] : s_misoo;
  assign s_scki  = loop_en ? m_scko : tb_scki;
  assign s_ssn   = loop_en ? m_spssn_o[0] : tb_ssn;
  assign s_mosii = loop_en ? m_mosio : tb_mosi;

  // Behavioural mode-0 slave: next bit appears on each falling SCK.
  always @(negedge m_scko) if (use_model) model_sh = {model_sh[6:0], 1'b0};

  spi_sfr_core u_master (
    .clk(clk), .rst_n(rst_n), .sfraddr_w(m_aw), .sfraddr_r(m_ar), .sfrwe(m_we),
    .spssn_i(m_spssn_i), .spidata_i(m_din), .mosii(1'b0), .misoi(m_misoi),
    .scki(1'b0), .ssn(1'b1), .spssn_o(m_spssn_o), .sfrdatao(m_sfrdo),
    .intspi(m_int), .mosio(m_mosio), .misoo(m_misoo), .scko(m_scko), .SPC0(m_spc0)
  );

  spi_sfr_core u_slave (
    .clk(clk), .rst_n(rst_n), .sfraddr_w(s_aw), .sfraddr_r(s_ar), .sfrwe(s_we),
    .spssn_i(8'hFF), .spidata_i(s_din), .mosii(s_mosii), .misoi(1'b0),
    .scki(s_scki), .ssn(s_ssn), .spssn_o(s_spssn_o), .sfrdatao(s_sfrdo),
    .intspi(s_int), .mosio(s_mosio), .misoo(s_misoo), .scko(s_scko), .SPC0(s_spc0)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_m(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    m_aw = a; m_din = d; m_we = 1'b1;
    @(posedge clk); #1;
    m_we = 1'b0;
  endtask

  task automatic wr_s(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    s_aw = a; s_din = d; s_we = 1'b1;
    @(posedge clk); #1;
    s_we = 1'b0;
  endtask

  // Watches a master transfer: MOSI at each rising SCK, cycles until SPIF.
  task automatic xfer_capture(input int collide_at, output logic [7:0] mo,
                              output int done_cyc, output int pulses);
    logic prev;
    prev = m_scko; mo = 8'd0; pulses = 0; done_cyc = -1;
    m_ar = 3'd4;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk); #1;
      m_we = 1'b0;
      if (c == collide_at) begin
        m_aw = 3'd3; m_din = 8'h18; m_we = 1'b1;
      end
      if (m_scko && !prev) begin
        mo = {mo[6:0], m_mosio};
        pulses++;
      end
      prev = m_scko;
      if (m_sfrdo[7]) begin
        done_cyc = c;
        break;
      end
    end
    m_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (m_spssn_o !== 8'hFF) begin
      $display("FAIL reset_spssn: got %h expected ff", m_spssn_o); miscompares++;
    end
    vectors++;
    if ({m_scko, m_int, m_mosio, m_spc0, s_misoo} !== 5'b0) begin
      $display("FAIL reset_outputs: got %b expected 00000",
               {m_scko, m_int, m_mosio, m_spc0, s_misoo});
      miscompares++;
    end
    for (int a = 0; a < 8; a++) begin
      m_ar = 3'(a); #1;
      vectors++;
      if (m_sfrdo !== 8'h00) begin
        $display("FAIL reset_sfr[%0d]: got %h expected 00", a, m_sfrdo); miscompares++;
      end
    end
    rst_n = 1'b1;
    wait_clk(2);
  endtask

  task automatic test_master_mode0;
    logic [7:0] mo, got;
    int dc, pl;
    use_model = 1'b1; model_sh = 8'h3C;
    m_spssn_i = 8'hFE;
    wr_m(3'd2, 8'h00);
    wr_m(3'd0, 8'h50);
    wait_clk(2);
    vectors++;
    if (m_spssn_o !== 8'hFE) begin
      $display("FAIL m0_spssn: got %h expected fe", m_spssn_o); miscompares++;
    end
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    wr_m(3'd3, 8'hA5);
    xfer_capture(0, mo, dc, pl);
    got = exp_q.pop_front();
    vectors++;
    if (mo !== got) begin
      $display("FAIL m0_mosi: got %h expected %h", mo, got); miscompares++;
    end
    vectors++;
    if (dc !== 17 || pl !== 8) begin
      $display("FAIL m0_timing: got %0d clk/%0d pulses expected 17/8", dc, pl); miscompares++;
    end
    m_ar = 3'd3; #1;
    got = exp_q.pop_front();
    vectors++;
    if (m_sfrdo !== got) begin
      $display("FAIL m0_rx: got %h expected %h", m_sfrdo, got); miscompares++;
    end
    m_ar = 3'd4; #1;
    vectors++;
    if (m_sfrdo !== 8'h80 || m_scko !== 1'b0) begin
      $display("FAIL m0_status: got %h/%b expected 80/0", m_sfrdo, m_scko); miscompares++;
    end
  endtask

  task automatic test_wcol;
    logic [7:0] mo, got;
    int dc, pl;
    wr_m(3'd2, 8'h03);
    exp_q.push_back(8'hC3);
    wr_m(3'd3, 8'hC3);
    xfer_capture(20, mo, dc, pl);
    got = exp_q.pop_front();
    vectors++;
    if (mo !== got) begin
      $display("FAIL wcol_mosi: got %h expected %h", mo, got); miscompares++;
    end
    vectors++;
    if (dc !== 65) begin
      $display("FAIL wcol_timing: got %0d expected 65", dc); miscompares++;
    end
    m_ar = 3'd4; #1;
    vectors++;
    if (m_sfrdo !== 8'hC0) begin
      $display("FAIL wcol_status: got %h expected c0", m_sfrdo); miscompares++;
    end
  endtask

  task automatic test_intspi;
    logic [7:0] mo;
    int dc, pl;
    wr_m(3'd1, 8'h01);
    vectors++;
    if (m_int !== 1'b1) begin
      $display("FAIL int_set: got %b expected 1", m_int); miscompares++;
    end
    wr_m(3'd3, 8'h00);
    vectors++;
    if (m_int !== 1'b0) begin
      $display("FAIL int_clr_spdr: got %b expected 0", m_int); miscompares++;
    end
    xfer_capture(0, mo, dc, pl);
    vectors++;
    if (m_int !== 1'b1 || dc !== 65) begin
      $display("FAIL int_done: got %b/%0d expected 1/65", m_int, dc); miscompares++;
    end
    wr_m(3'd4, 8'h80);
    vectors++;
    if (m_int !== 1'b0) begin
      $display("FAIL int_clr_spsr: got %b expected 0", m_int); miscompares++;
    end
    wr_m(3'd1, 8'h00);
  endtask

  task automatic test_all_modes;
    logic [7:0] mt, st, got;
    logic done;
    use_model = 1'b0; loop_en = 1'b1;
    m_spssn_i = 8'hFF;
    wr_m(3'd2, 8'h03);
    for (int m = 0; m < 4; m++) begin
      wr_s(3'd0, 8'h40 | 8'(m << 2));
      wr_m(3'd0, 8'h50 | 8'(m << 2));
      wait_clk(3);
      for (int i = 0; i < 20; i++) begin
        mt = 8'($urandom_range(0, 255));
        st = 8'($urandom_range(0, 255));
        wr_s(3'd3, st);
        exp_q.push_back(st);
        sexp_q.push_back(mt);
        m_spssn_i = 8'hFE;
        wait_clk(3);
        wr_m(3'd3, mt);
        done = 1'b0;
        m_ar = 3'd4;
        for (int c = 0; c < 300; c++) begin
          @(posedge clk); #1;
          if (m_sfrdo[7]) begin
            done = 1'b1;
            break;
          end
        end
        wait_clk(4);
        m_spssn_i = 8'hFF;
        vectors++;
        if (done !== 1'b1) begin
          $display("FAIL loop_timeout mode %0d byte %0d: got no SPIF expected SPIF", m, i);
          miscompares++;
        end
        m_ar = 3'd3; #1;
        got = exp_q.pop_front();
        vectors++;
        if (m_sfrdo !== got) begin
          $display("FAIL loop_master_rx mode %0d byte %0d: got %h expected %h", m, i, m_sfrdo, got);
          miscompares++;
        end
        s_ar = 3'd4; #1;
        vectors++;
        if (s_sfrdo[7] !== 1'b1) begin
          $display("FAIL loop_slave_spif mode %0d byte %0d: got %b expected 1", m, i, s_sfrdo[7]);
          miscompares++;
        end
        s_ar = 3'd3; #1;
        got = sexp_q.pop_front();
        vectors++;
        if (s_sfrdo !== got) begin
          $display("FAIL loop_slave_rx mode %0d byte %0d: got %h expected %h", m, i, s_sfrdo, got);
          miscompares++;
        end
        wait_clk(3);
      end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_slave_abort;
    logic [7:0] mi, got, pat;
    tb_ssn = 1'b1; tb_scki = 1'b0; tb_mosi = 1'b0;
    wr_s(3'd0, 8'h40);
    wr_s(3'd4, 8'h80);
    wr_s(3'd3, 8'h5A);
    wait_clk(3);
    tb_ssn = 1'b0;
    wait_clk(3);
    for (int b = 0; b < 4; b++) begin
      tb_mosi = 1'b1; wait_clk(3);
      tb_scki = 1'b1; wait_clk(3);
      tb_scki = 1'b0; wait_clk(3);
    end
    tb_ssn = 1'b1;
    wait_clk(4);
    s_ar = 3'd4; #1;
    vectors++;
    if (s_sfrdo !== 8'h00) begin
      $display("FAIL abort_status: got %h expected 00", s_sfrdo); miscompares++;
    end
    pat = 8'h96;
    wr_s(3'd3, 8'h5A);
    exp_q.push_back(8'h5A);
    exp_q.push_back(pat);
    tb_ssn = 1'b0;
    wait_clk(3);
    mi = 8'd0;
    for (int b = 7; b >= 0; b--) begin
      tb_mosi = pat[b]; wait_clk(3);
      mi = {mi[6:0], s_misoo};
      tb_scki = 1'b1; wait_clk(3);
      tb_scki = 1'b0; wait_clk(3);
    end
    s_ar = 3'd4; #1;
    vectors++;
    if (s_sfrdo[7] !== 1'b1) begin
      $display("FAIL abort_next_spif: got %b expected 1", s_sfrdo[7]); miscompares++;
    end
    got = exp_q.pop_front();
    vectors++;
    if (mi !== got) begin
      $display("FAIL abort_next_miso: got %h expected %h", mi, got); miscompares++;
    end
    s_ar = 3'd3; #1;
    got = exp_q.pop_front();
    vectors++;
    if (s_sfrdo !== got) begin
      $display("FAIL abort_next_rx: got %h expected %h", s_sfrdo, got); miscompares++;
    end
    tb_ssn = 1'b1;
    wait_clk(2);
  endtask

  task automatic test_reset_midxfer;
    use_model = 1'b1; model_sh = 8'h00;
    m_spssn_i = 8'hFE;
    wr_m(3'd0, 8'h50);
    wr_m(3'd3, 8'hFF);
    wait_clk(10);
    vectors++;
    if (m_spssn_o !== 8'hFE || m_mosio !== 1'b1) begin
      $display("FAIL midxfer_active: got %h/%b expected fe/1", m_spssn_o, m_mosio); miscompares++;
    end
    rst_n = 1'b0;
    #1;
    m_ar = 3'd4; #1;
    vectors++;
    if ({m_spssn_o, m_scko, m_mosio, m_sfrdo} !== {8'hFF, 2'b00, 8'h00}) begin
      $display("FAIL midxfer_reset: got %h/%b/%b/%h expected ff/0/0/00",
               m_spssn_o, m_scko, m_mosio, m_sfrdo);
      miscompares++;
    end
    #2 rst_n = 1'b1;
    wait_clk(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    m_aw = 3'd0; m_ar = 3'd0; m_we = 1'b0; m_din = 8'd0; m_spssn_i = 8'hFF;
    s_aw = 3'd0; s_ar = 3'd0; s_we = 1'b0; s_din = 8'd0;
    loop_en = 1'b0; use_model = 1'b0; model_sh = 8'd0;
    tb_scki = 1'b0; tb_ssn = 1'b1; tb_mosi = 1'b0;
    #2;
    test_reset();
    test_master_mode0();
    test_wcol();
    test_intspi();
    test_all_modes();
    test_slave_abort();
    test_reset_midxfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
